step_segment_runner: RTL
========================

// Module: step_segment_runner
// PURPOSE
//  Motion-segment consumer placed directly downstream of the byte-to-record FIFO.
//  - Pops one 128-bit segment record whenever the FIFO reports a record available.
//  - Decodes the record and emits step/dir pulses to the stepper drivers: N steps at a fixed period.
//  - Decoupling through the FIFO lets the host stream segments ahead of execution.
// PARAMETERS
//  RECORD_BITS       128  record width; equals the FIFO data_out width (16 bytes x 8 bits)
//  AXES              8    number of step/dir channels, 1..8 (mask and dir fields are one byte)
//  PULSE_CYCLES      4    step high time in clk cycles, >=1
//  DIR_SETUP_CYCLES  8    dir-to-first-step setup time in clk cycles, >=1
//  CNT_WIDTH         32   width of step and period counters
// PORTS
//  clk             in   1            single clock; all logic on rising edge
//  reset           in   1            synchronous, active-high reset
//  enable          in   1            1 = fetch new records; 0 = hold in IDLE once current segment ends
//  fifo_data       in   RECORD_BITS  FIFO data_out; byte k = bits [8k+7:8k]
//  fifo_empty      in   1            FIFO empty (no complete record)
//  fifo_read_en    out  1            pop one record (combinational, one cycle per record)
//  step            out  AXES         step pulses, registered
//  dir             out  AXES         direction levels, registered
//  busy            out  1            segment in progress (state != IDLE)
//  segments_done   out  16           count of completed records, wraps at 2^16
// BEHAVIOUR
//  Record format (little endian):
//   - bytes 0-3:  steps S (uint32)
//   - bytes 4-7:  period P in clk cycles (uint32)
//   - byte 8:     dir bits
//   - byte 9:     axis mask
//   - bytes 10-15: reserved, ignored
//  Reset: state IDLE; step=0, dir=0, busy=0, segments_done=0; all counters 0.
//   - Reset mid-segment discards the segment and drops step the next cycle.
//  States:
//   - IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW.
//  IDLE:
//   - fifo_read_en = enable && !fifo_empty.
//   - On that same edge, latch S, P, dir byte and mask from fifo_data. The FIFO pops at that edge; its data is valid while !fifo_empty.
//   - Next state:
//     - S==0: stay IDLE, segments_done+1, no pulses, dir unchanged.
//     - new dir[AXES-1:0] != current dir: update dir, go to DIR_SETUP for DIR_SETUP_CYCLES cycles.
//     - otherwise: go directly to PULSE_HIGH.
//  PULSE_HIGH:
//   - step = mask[AXES-1:0] for exactly PULSE_CYCLES cycles, then PULSE_LOW.
//  PULSE_LOW:
//   - step = 0 for Peff-PULSE_CYCLES cycles, where Peff = max(P, PULSE_CYCLES+1).
//   - Step rising edges are therefore exactly Peff cycles apart.
//   - On end of the S-th PULSE_LOW: segments_done+1 and go to IDLE.
//   - Back-to-back: from IDLE, the next record may be fetched in the very next cycle.
//  Fixed timing:
//   - step is high only in PULSE_HIGH cycles; dir changes only in the IDLE fetch cycle.
//   - Latency with dir unchanged: step rises in the cycle after the fetch.
//   - Latency with dir changed: step rises DIR_SETUP_CYCLES+1 cycles after the fetch.
//  Flow control:
//   - enable falling mid-segment does not abort; the segment completes, then IDLE holds.
//   - fifo_read_en is never asserted outside IDLE or while fifo_empty=1 (no underflow pop).
//  Width rules:
//   - Counters are CNT_WIDTH bits with no overflow; S and P up to 2^32-1 supported.
//   - segments_done wraps from 0xFFFF to 0x0000.
// TESTING
//  - reset, fifo_empty=1, enable=1 for 50 cycles -> fifo_read_en never 1; step=0, dir=0, busy=0.
//  - record S=3, P=10, dir=0x01, mask=0x03 ->
//    - one fifo_read_en pulse; dir[0]=1 from the cycle after the fetch;
//    - step[1:0]=2'b11 high 4 cycles x3, rises 10 apart; first rise 9 cycles after fetch;
//    - segments_done=1, busy falls.
//  - record S=2, P=1 (clamped to 5) with dir unchanged -> first step rise in the cycle after the fetch; rises 5 cycles apart.
//  - two records queued, S=0 then S=1 -> two consecutive single-cycle fetches; segments_done 0->1->2; exactly one step pulse.
//  - reset asserted during the 2nd PULSE_HIGH of S=5 ->
//    - step=0 next cycle; dir=0; segments_done=0;
//    - no further pulses until a new record is fetched.
//  - enable=0 after the fetch of S=4 -> all 4 pulses emitted; no further fetch while the FIFO is non-empty until enable=1.

Source files
------------

// File: rtl/step_segment_runner.sv
// Consumes 128-bit motion-segment records from the record FIFO and turns each one
// into S step pulses on the masked axes at a fixed period, with direction setup time.
module step_segment_runner #(
    parameter int RECORD_BITS      = 128,
    parameter int AXES             = 8,
    parameter int PULSE_CYCLES     = 4,
    parameter int DIR_SETUP_CYCLES = 8,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [RECORD_BITS-1:0] fifo_data,
    input  logic                   fifo_empty,
    output logic                   fifo_read_en,
    output logic [AXES-1:0]        step,
    output logic [AXES-1:0]        dir,
    output logic                   busy,
    output logic [15:0]            segments_done
);

    typedef enum logic [1:0] {IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] PULSE_LEN  = CNT_WIDTH'(PULSE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] MIN_PERIOD = CNT_WIDTH'(PULSE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] SETUP_LEN  = CNT_WIDTH'(DIR_SETUP_CYCLES);
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   steps_q, steps_d;
    logic [CNT_WIDTH-1:0]   low_len_q, low_len_d;
    logic [AXES-1:0]        mask_q, mask_d;
    logic [AXES-1:0]        dir_q, dir_d;
    logic [AXES-1:0]        step_q, step_d;
    logic [15:0]            done_q, done_d;

    logic [CNT_WIDTH-1:0]   rec_steps;
    logic [CNT_WIDTH-1:0]   rec_period;
    logic [CNT_WIDTH-1:0]   rec_low_len;
    logic [AXES-1:0]        rec_dir;
    logic [AXES-1:0]        rec_mask;
    logic                   unused_record;

    assign rec_steps     = CNT_WIDTH'(fifo_data[31:0]);
    assign rec_period    = CNT_WIDTH'(fifo_data[63:32]);
    assign rec_dir       = fifo_data[64 +: AXES];
    assign rec_mask      = fifo_data[72 +: AXES];
    assign unused_record = ^fifo_data;

    // Short periods are stretched so every pulse keeps at least one low cycle.
    assign rec_low_len = ((rec_period < MIN_PERIOD) ? MIN_PERIOD : rec_period) - PULSE_LEN;

    assign fifo_read_en  = (state_q == IDLE) && enable && !fifo_empty;
    assign step          = step_q;
    assign dir           = dir_q;
    assign busy          = (state_q != IDLE);
    assign segments_done = done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        steps_d   = steps_q;
        low_len_d = low_len_q;
        mask_d    = mask_q;
        dir_d     = dir_q;
        done_d    = done_q;

        case (state_q)
            IDLE: begin
                if (fifo_read_en) begin
                    steps_d   = rec_steps;
                    low_len_d = rec_low_len;
                    mask_d    = rec_mask;
                    if (rec_steps == '0) begin
                        done_d = done_q + 16'd1;
                    end else if (rec_dir != dir_q) begin
                        dir_d   = rec_dir;
                        state_d = DIR_SETUP;
                        cnt_d   = SETUP_LEN - ONE;
                    end else begin
                        state_d = PULSE_HIGH;
                        cnt_d   = PULSE_LEN - ONE;
                    end
                end
            end
            DIR_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE_HIGH;
                    cnt_d   = PULSE_LEN - ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            PULSE_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = PULSE_LOW;
                    cnt_d   = low_len_q - ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            PULSE_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (steps_q <= ONE) begin
                    state_d = IDLE;
                    steps_d = '0;
                    done_d  = done_q + 16'd1;
                end else begin
                    state_d = PULSE_HIGH;
                    steps_d = steps_q - ONE;
                    cnt_d   = PULSE_LEN - ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Step is registered from the next state so it lines up exactly with PULSE_HIGH.
        step_d = (state_d == PULSE_HIGH) ? mask_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            steps_q   <= '0;
            low_len_q <= '0;
            mask_q    <= '0;
            dir_q     <= '0;
            step_q    <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            steps_q   <= steps_d;
            low_len_q <= low_len_d;
            mask_q    <= mask_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            done_q    <= done_d;
        end
    end

endmodule
